// File: rtl/mem_access_ctrl.sv
// Sequencer for the MAR/MDR/RAM datapath: arbitrates fetch vs data, steps one access.
// Define MEM_CTRL_RR_EN for round-robin arbitration (default: data over fetch).
module mem_access_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              done,
  output logic              done_id,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_out_en,
  input  logic [DATA_W-1:0] bus_in,
  output logic              mar_in,
  output logic              mdr_in,
  output logic              mdr_read,
  output logic              mdr_out,
  output logic              mem_read,
  output logic              mem_write
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, WRITE, READ, CAPTURE, DRIVE, DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              id_q;
  logic [CNT_W-1:0]  cnt;
  logic              any_req;
  logic              grant_data;
  logic              grant;

  assign any_req = fetch_req | data_req;
  assign grant   = (state == IDLE) & any_req;
  assign busy    = (state != IDLE);

`ifdef MEM_CTRL_RR_EN
  logic last_grant;

  // On a tie the requester that did not win last time goes first
  assign grant_data = data_req & (~fetch_req | ~last_grant);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      last_grant <= 1'b1;
    end else if (grant) begin
      last_grant <= grant_data;
    end
  end
`else
  assign grant_data = data_req;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      id_q    <= 1'b0;
    end else if (grant) begin
      addr_q  <= grant_data ? data_addr : fetch_addr;
      we_q    <= grant_data & data_we;
      wdata_q <= data_wdata;
      id_q    <= grant_data;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt <= '0;
    end else if (state == ADDR || state == WDATA) begin
      cnt <= CNT_INIT;
    end else if ((state == READ || state == WRITE) && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rdata <= '0;
    end else if (state == DRIVE) begin
      rdata <= bus_in;
    end
  end

  always_comb begin
    state_nx   = state;
    bus_out    = '0;
    bus_out_en = 1'b0;
    mar_in     = 1'b0;
    mdr_in     = 1'b0;
    mdr_read   = 1'b0;
    mdr_out    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    done       = 1'b0;
    done_id    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) state_nx = ADDR;
      end
      ADDR: begin
        bus_out    = DATA_W'(addr_q);
        bus_out_en = 1'b1;
        mar_in     = 1'b1;
        state_nx   = we_q ? WDATA : READ;
      end
      WDATA: begin
        bus_out    = wdata_q;
        bus_out_en = 1'b1;
        mdr_in     = 1'b1;
        state_nx   = WRITE;
      end
      WRITE: begin
        mem_write = 1'b1;
        if (cnt == '0) state_nx = DONE;
      end
      READ: begin
        mem_read = 1'b1;
        if (cnt == '0) state_nx = CAPTURE;
      end
      CAPTURE: begin
        mem_read = 1'b1;
        mdr_in   = 1'b1;
        mdr_read = 1'b1;
        state_nx = DRIVE;
      end
      DRIVE: begin
        mdr_out  = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        done_id  = id_q;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with MAR/MDR/RAM models (MEM_LAT=1 and 3).
module tb_mem_access_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;

  localparam logic [9:0] V_IDLE  = 10'b0000000000;
  localparam logic [9:0] V_ADDR  = 10'b0011100000;
  localparam logic [9:0] V_READ  = 10'b0010000010;
  localparam logic [9:0] V_CAP   = 10'b0010011010;
  localparam logic [9:0] V_DRV   = 10'b0010000100;
  localparam logic [9:0] V_DONEF = 10'b1010000000;
  localparam logic [9:0] V_DONED = 10'b1110000000;
  localparam logic [9:0] V_WDATA = 10'b0011010000;
  localparam logic [9:0] V_WRITE = 10'b0010000001;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  logic          fetch_req, data_req, data_we;
  logic [AW-1:0] fetch_addr, data_addr;
  logic [DW-1:0] data_wdata;
  logic          done, done_id, busy, bus_out_en;
  logic          mar_in, mdr_in, mdr_read, mdr_out, mem_read, mem_write;
  logic [DW-1:0] rdata, bus_out, bus_in;

  logic          fetch_req3;
  logic [AW-1:0] fetch_addr3;
  logic          data_req3 = 1'b0;
  logic          data_we3 = 1'b0;
  logic [AW-1:0] data_addr3 = '0;
  logic [DW-1:0] data_wdata3 = '0;
  logic          done3, done_id3, busy3, bus_out_en3;
  logic          mar_in3, mdr_in3, mdr_read3, mdr_out3, mem_read3, mem_write3;
  logic [DW-1:0] rdata3, bus_out3, bus_in3;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut (
    .clock(clock), .clear(clear),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .done(done), .done_id(done_id), .rdata(rdata), .busy(busy),
    .bus_out(bus_out), .bus_out_en(bus_out_en), .bus_in(bus_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .mdr_read(mdr_read),
    .mdr_out(mdr_out), .mem_read(mem_read), .mem_write(mem_write)
  );

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut3 (
    .clock(clock), .clear(clear),
    .fetch_req(fetch_req3), .fetch_addr(fetch_addr3),
    .data_req(data_req3), .data_we(data_we3),
    .data_addr(data_addr3), .data_wdata(data_wdata3),
    .done(done3), .done_id(done_id3), .rdata(rdata3), .busy(busy3),
    .bus_out(bus_out3), .bus_out_en(bus_out_en3), .bus_in(bus_in3),
    .mar_in(mar_in3), .mdr_in(mdr_in3), .mdr_read(mdr_read3),
    .mdr_out(mdr_out3), .mem_read(mem_read3), .mem_write(mem_write3)
  );

  // Datapath models: MAR, MDR and RAM, preloaded on the first edge
  logic [DW-1:0] ram1 [512];
  logic [AW-1:0] mar1;
  logic [DW-1:0] mdr1;
  logic          init1 = 1'b0;
  assign bus_in = mdr1;

  always @(posedge clock) begin
    if (!init1) begin
      for (int i = 0; i < 512; i++) ram1[i] <= 32'hA5A50000 | i;
      ram1[9'h055] <= 32'h12345678;
      init1 <= 1'b1;
    end else begin
      if (mar_in) mar1 <= bus_out[AW-1:0];
      if (mdr_in) mdr1 <= mdr_read ? ram1[mar1] : bus_out;
      if (mem_write) ram1[mar1] <= mdr1;
    end
  end

  logic [DW-1:0] ram3 [512];
  logic [AW-1:0] mar3;
  logic [DW-1:0] mdr3;
  logic          init3 = 1'b0;
  assign bus_in3 = mdr3;

  always @(posedge clock) begin
    if (!init3) begin
      for (int i = 0; i < 512; i++) ram3[i] <= 32'h5A5A0000 | i;
      ram3[9'h033] <= 32'hCAFEF00D;
      init3 <= 1'b1;
    end else begin
      if (mar_in3) mar3 <= bus_out3[AW-1:0];
      if (mdr_in3) mdr3 <= mdr_read3 ? ram3[mar3] : bus_out3;
      if (mem_write3) ram3[mar3] <= mdr3;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [9:0] vec1();
    return {done, done_id, busy, bus_out_en, mar_in,
            mdr_in, mdr_read, mdr_out, mem_read, mem_write};
  endfunction

  function automatic logic [9:0] vec3();
    return {done3, done_id3, busy3, bus_out_en3, mar_in3,
            mdr_in3, mdr_read3, mdr_out3, mem_read3, mem_write3};
  endfunction

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  logic [9:0] ld_seq [5];
  logic [9:0] st_seq [4];
  logic [2:0] arb_ids;
  int mr_n, mr_first, mr_last, d_cyc;

  initial begin
    ld_seq = '{V_ADDR, V_READ, V_CAP, V_DRV, V_DONEF};
    st_seq = '{V_ADDR, V_WDATA, V_WRITE, V_DONED};
`ifdef MEM_CTRL_RR_EN
    arb_ids = 3'b010;
`else
    arb_ids = 3'b111;
`endif
    fetch_req = 0; data_req = 0; data_we = 0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0;
    fetch_req3 = 0; fetch_addr3 = '0;

    // Reset state
    clear = 0;
    repeat (3) step();
    chk("rst_vec", 32'(vec1()), 32'(V_IDLE));
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus", bus_out, 32'h0);
    chk("rst_vec3", 32'(vec3()), 32'(V_IDLE));
    clear = 1;
    step();

    // Fetch load, MEM_LAT=1
    fetch_addr = 9'h055;
    fetch_req  = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("ld_trace", 32'(vec1()), 32'(ld_seq[i]));
      if (i == 0) chk("ld_mar_bus", bus_out, 32'h00000055);
      if (i == 4) begin
        chk("ld_rdata", rdata, 32'h12345678);
        fetch_req = 0;
      end
      step();
    end
    chk("ld_idle", 32'(vec1()), 32'(V_IDLE));

    // Data store
    data_addr  = 9'h1FF;
    data_wdata = 32'hDEADBEEF;
    data_we    = 1;
    data_req   = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("st_trace", 32'(vec1()), 32'(st_seq[i]));
      if (i == 0) chk("st_mar_bus", bus_out, 32'h000001FF);
      if (i == 1) chk("st_wdata_bus", bus_out, 32'hDEADBEEF);
      if (i == 3) data_req = 0;
      step();
    end
    chk("st_ram", ram1[9'h1FF], 32'hDEADBEEF);
    chk("st_rdata_kept", rdata, 32'h12345678);

    // Both requesters held
    data_we    = 0;
    data_addr  = 9'h010;
    fetch_addr = 9'h020;
    data_req   = 1;
    fetch_req  = 1;
    for (int i = 0; i < 3; i++) begin
      wait_done("arb");
      chk("arb_id", 32'(done_id), 32'(arb_ids[i]));
      chk("arb_rdata", rdata, arb_ids[i] ? 32'hA5A50010 : 32'hA5A50020);
      if (i == 2) data_req = 0;
      step();
    end
    wait_done("arb_fetch");
    chk("arb_fetch_id", 32'(done_id), 32'd0);
    chk("arb_fetch_rdata", rdata, 32'hA5A50020);
    fetch_req = 0;
    step();
    chk("arb_idle", 32'(busy), 32'd0);

    // MEM_LAT=3 load
    fetch_addr3 = 9'h033;
    fetch_req3  = 1;
    step();
    mr_n = 0; mr_first = 0; mr_last = 0; d_cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      if (mem_read3) begin
        mr_n++;
        if (mr_first == 0) mr_first = c;
        mr_last = c;
      end
      if (done3 && d_cyc == 0) begin
        d_cyc = c;
        fetch_req3 = 0;
      end
      step();
    end
    chk("lat3_mr_count", mr_n, 4);
    chk("lat3_mr_first", mr_first, 2);
    chk("lat3_mr_span", mr_last - mr_first, 3);
    chk("lat3_done_cyc", d_cyc, 7);
    chk("lat3_rdata", rdata3, 32'hCAFEF00D);

    // Reset during READ
    fetch_addr = 9'h055;
    fetch_req  = 1;
    step();
    step();
    chk("clr_pre_read", 32'(vec1()), 32'(V_READ));
    #1 clear = 0;
    #1;
    chk("clr_async_vec", 32'(vec1()), 32'(V_IDLE));
    chk("clr_async_rdata", rdata, 32'h0);
    step();
    chk("clr_no_done", 32'(done), 32'd0);
    clear = 1;
    step();
    chk("clr_restart", 32'(vec1()), 32'(V_ADDR));
    chk("clr_restart_bus", bus_out, 32'h00000055);
    wait_done("clr");
    chk("clr_done_id", 32'(done_id), 32'd0);
    chk("clr_rdata", rdata, 32'h12345678);
    fetch_req = 0;
    step();

    // Address change and req drop after grant
    data_we   = 0;
    data_addr = 9'h010;
    data_req  = 1;
    step();
    data_addr = 9'h020;
    data_req  = 0;
    chk("late_bus", bus_out, 32'h00000010);
    wait_done("late");
    chk("late_id", 32'(done_id), 32'd1);
    chk("late_rdata", rdata, 32'hA5A50010);
    step();
    chk("late_single", 32'(done), 32'd0);
    chk("late_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencer for the MAR/MDR/RAM memory datapath.
- Arbitrates between two requesters: instruction fetch (read-only) and data (load/store).
- Drives the MAR/MDR/memory strobes cycle by cycle to complete one access at a time.
- Returns load data to the requester with a one-cycle done pulse.

Parameters:
- ADDR_W, 9: memory address width (512-word RAM).
- DATA_W, 32: bus/data width.
- MEM_LAT, 1: cycles mem_read/mem_write held before data is valid or the write is committed. Must be >= 1; 0 is illegal.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset (0 = reset).
- fetch_req  in  1  fetch access request; held until done.
- fetch_addr  in  ADDR_W  fetch address.
- data_req  in  1  data access request; held until done.
- data_we  in  1  1 = store, 0 = load.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  requester completed: 0 = fetch, 1 = data; valid with done.
- rdata  out  DATA_W  load result; valid with done, held until the next load completes.
- busy  out  1  high in every state except IDLE.
- bus_out  out  DATA_W  value the controller drives onto the bus.
- bus_out_en  out  1  controller owns the bus this cycle.
- bus_in  in  DATA_W  bus value (MDR output during DRIVE).
- mar_in  out  1  MAR load strobe.
- mdr_in  out  1  MDR load strobe.
- mdr_read  out  1  MDR input mux: 1 = memory data, 0 = bus.
- mdr_out  out  1  MDR drives the bus.
- mem_read  out  1  RAM read.
- mem_write  out  1  RAM write.

Behaviour:
- Reset (clear = 0, asynchronous): state = IDLE; all strobes, bus_out_en, done, done_id and busy = 0; bus_out = 0; rdata = 0; wait counter = 0; last_grant = data.
- Reset mid-access: the access is aborted with no done pulse and strobes drop immediately.
- Moore outputs: all strobes and bus_out are decoded from registered state and latched request fields only. There is no combinational path from any *_req input to any output.

FSM states and outputs:
- IDLE: no strobes. If any request is high, arbitrate at the clock edge. Latch the winner's addr, we and wdata plus its id; fetch is always a load. Go to ADDR.
- ADDR: bus_out = zero-extended latched addr, bus_out_en = 1, mar_in = 1. Next state: WDATA if store, else READ.
- WDATA (store only): bus_out = latched wdata, bus_out_en = 1, mdr_in = 1, mdr_read = 0. Next state: WRITE.
- WRITE: mem_write = 1 for MEM_LAT cycles (counter loaded with MEM_LAT-1 on entry), then DONE.
- READ: mem_read = 1 for MEM_LAT cycles, then CAPTURE.
- CAPTURE: mem_read = 1, mdr_in = 1, mdr_read = 1. Next state: DRIVE.
- DRIVE: mdr_out = 1. rdata <= bus_in at the end of this cycle. Next state: DONE.
- DONE: done = 1, done_id = latched id. Next state: IDLE.

Latency and handshake:
- Latency from the IDLE edge that grants to done high: load 4+MEM_LAT cycles; store 3+MEM_LAT cycles.
- Request inputs are sampled only in IDLE. Changes to addr/data after the grant are ignored.
- A req dropped after the grant does not abort the access; done still pulses.
- A req still high in the IDLE cycle after DONE is treated as a new request.
- The non-granted requester waits with its req held. It is never lost.
- rdata is unchanged by stores.

Optional Feature:
- Macro: MEM_CTRL_RR_EN.
- Defined: round-robin arbitration. On simultaneous requests the winner is the requester not in last_grant; last_grant updates on every grant. Reset value makes fetch win the first tie.
- Undefined: fixed priority, data over fetch. last_grant is not implemented.

Test Plan:
- Fetch load, MEM_LAT=1, fetch_addr=0x055, RAM[0x055]=0x12345678, bus_in = MDR model -> mar_in with bus_out=0x00000055; mem_read for 2 cycles; mdr_in with mdr_read=1 in CAPTURE; done/done_id=0 five cycles after grant; rdata=0x12345678.
- Data store, data_addr=0x1FF, wdata=0xDEADBEEF -> WDATA drives 0xDEADBEEF with mdr_in=1, mdr_read=0; mem_write 1 cycle; done/done_id=1 at cycle 4; RAM[0x1FF]=0xDEADBEEF; rdata unchanged.
- fetch_req and data_req both high continuously -> undefined macro: data, data, ...; MEM_CTRL_RR_EN: fetch, data, fetch alternating; neither request is dropped.
- MEM_LAT=3, load -> mem_read high for exactly 4 consecutive cycles (READ×3 + CAPTURE); done at cycle 7.
- clear pulsed low during READ -> all strobes 0 asynchronously; no done; after release a held req restarts from ADDR.
- data_addr changed and data_req dropped one cycle after grant -> original address used and done still pulses once.
